// File: rtl/axi_hbm_pkg.sv
// Shared AXI3 encodings and FSM state types for the HBM pseudo-channel responder.
package axi_hbm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_32B    = 3'd5;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only full-width INCR bursts match the HBM port geometry.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_32B);
  endfunction

endpackage

// File: rtl/axi_sat_counter.sv
// Saturating statistics counter: adds 0/1/2 per cycle when inc_i, sticks at all-ones.
// One cycle update latency, no backpressure.
module axi_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic [1:0]   amt_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W:0]   sum_d;

  always_comb begin
    sum_d = {1'b0, cnt_q} + {{(W - 1){1'b0}}, amt_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= sum_d[W] ? '1 : sum_d[W-1:0];
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_hbm_responder.sv
// AXI3 responder standing in for an HBM pseudo-channel: sinks write bursts, returns address-pattern reads.
// All outputs registered; one outstanding burst per path, honours bready/rready stalls.
module axi_hbm_responder
  import axi_hbm_pkg::*;
#(
  parameter int ADDR_W = 33,
  parameter int DATA_W = 256,
  parameter int ID_W   = 6,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [1:0]          axi_awburst,
  input  logic [LEN_W-1:0]    axi_awlen,
  input  logic [ID_W-1:0]     axi_awid,
  input  logic [2:0]          axi_awsize,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [1:0]          axi_arburst,
  input  logic [LEN_W-1:0]    axi_arlen,
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [2:0]          axi_arsize,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [ID_W-1:0]     axi_rid,
  output logic                axi_rlast,
  output logic [1:0]          axi_rresp,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [CNT_W-1:0]    wr_txn_cnt,
  output logic [CNT_W-1:0]    rd_txn_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int                RD_REPL    = DATA_W / 32;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

  // Write data and address are intentionally discarded.
  logic unused_wr_payload;
  assign unused_wr_payload = ^{axi_wdata, axi_wstrb, axi_awaddr};

  wr_state_t         wr_state_q;
  logic              awready_q, wready_q, bvalid_q, err_w_q;
  logic [ID_W-1:0]   awid_q, bid_q;
  logic [LEN_W-1:0]  awlen_q, wbeat_q;
  logic [1:0]        bresp_q;

  rd_state_t         rd_state_q;
  logic              arready_q, rvalid_q, rlast_q, err_r_q;
  logic [ID_W-1:0]   rid_q;
  logic [LEN_W-1:0]  arlen_q, rbeat_q;
  logic [1:0]        rresp_q;
  logic [ADDR_W-1:0] beat_addr_q;
  logic [DATA_W-1:0] rdata_q;

  logic              w_hs, w_hit_len, w_frame_err, b_done, r_hs, r_done;
  logic [LEN_W-1:0]  rbeat_d;
  logic [ADDR_W-1:0] beat_addr_d;
  logic [1:0]        err_amt;

  always_comb begin
    w_hs        = axi_wvalid && wready_q;
    w_hit_len   = (wbeat_q == awlen_q);
    w_frame_err = axi_wlast != w_hit_len;
    b_done      = bvalid_q && axi_bready;
    r_hs        = rvalid_q && axi_rready;
    r_done      = r_hs && rlast_q;
    rbeat_d     = rbeat_q + 1'b1;
    beat_addr_d = beat_addr_q + BEAT_BYTES;
    err_amt     = {1'b0, b_done && err_w_q} + {1'b0, r_done && err_r_q};
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      awid_q     <= '0;
      awlen_q    <= '0;
      wbeat_q    <= '0;
      err_w_q    <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi_awvalid && awready_q) begin
            awid_q     <= axi_awid;
            awlen_q    <= axi_awlen;
            wbeat_q    <= '0;
            err_w_q    <= burst_bad(axi_awburst, axi_awsize);
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wbeat_q <= wbeat_q + 1'b1;
            if (w_frame_err) err_w_q <= 1'b1;
            // Whichever comes first, wlast or the advertised length, closes the burst.
            if (axi_wlast || w_hit_len) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bid_q      <= awid_q;
              bresp_q    <= (err_w_q || w_frame_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (b_done) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rd_state_q  <= R_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rresp_q     <= RESP_OKAY;
      err_r_q     <= 1'b0;
      arlen_q     <= '0;
      rbeat_q     <= '0;
      beat_addr_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi_arvalid && arready_q) begin
            err_r_q     <= burst_bad(axi_arburst, axi_arsize);
            rresp_q     <= burst_bad(axi_arburst, axi_arsize) ? RESP_SLVERR : RESP_OKAY;
            rid_q       <= axi_arid;
            arlen_q     <= axi_arlen;
            rbeat_q     <= '0;
            beat_addr_q <= axi_araddr;
            rdata_q     <= {RD_REPL{axi_araddr[31:0]}};
            rlast_q     <= (axi_arlen == '0);
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b1;
            rd_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_done) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end else if (r_hs) begin
            rbeat_q     <= rbeat_d;
            beat_addr_q <= beat_addr_d;
            rdata_q     <= {RD_REPL{beat_addr_d[31:0]}};
            rlast_q     <= (rbeat_d == arlen_q);
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  axi_sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk_i(axi_aclk), .rst_i(axi_areset), .inc_i(b_done), .amt_i(2'd1), .cnt_o(wr_txn_cnt)
  );

  axi_sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk_i(axi_aclk), .rst_i(axi_areset), .inc_i(r_done), .amt_i(2'd1), .cnt_o(rd_txn_cnt)
  );

  axi_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i(axi_aclk), .rst_i(axi_areset), .inc_i(|err_amt), .amt_i(err_amt), .cnt_o(err_cnt)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bid     = bid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rid     = rid_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;
  assign axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_hbm_responder.sv
// Directed bench for axi_hbm_responder with hand-computed expectations.
module tb_axi_hbm_responder;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic [32:0]  awaddr = '0, araddr = '0;
  logic [1:0]   awburst = 2'b01, arburst = 2'b01;
  logic [3:0]   awlen = '0, arlen = '0;
  logic [5:0]   awid = '0, arid = '0;
  logic [2:0]   awsize = 3'd5, arsize = 3'd5;
  logic         awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic         arvalid = 1'b0, rready = 1'b0;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '1;
  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [5:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic [255:0] rdata;
  logic [31:0]  wr_cnt, rd_cnt, err_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  axi_hbm_responder dut (
    .axi_aclk(clk), .axi_areset(areset),
    .axi_awaddr(awaddr), .axi_awburst(awburst), .axi_awlen(awlen), .axi_awid(awid),
    .axi_awsize(awsize), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready),
    .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arburst(arburst), .axi_arlen(arlen), .axi_arid(arid),
    .axi_arsize(arsize), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rid(rid), .axi_rlast(rlast), .axi_rresp(rresp),
    .axi_rvalid(rvalid), .axi_rready(rready),
    .wr_txn_cnt(wr_cnt), .rd_txn_cnt(rd_cnt), .err_cnt(err_cnt)
  );

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [32:0] a, input logic [3:0] len, input logic [5:0] id,
                         input logic [1:0] burst, input logic [2:0] size);
    check_eq("awready_before_aw", awready, 1);
    awaddr = a; awlen = len; awid = id; awburst = burst; awsize = size; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_eq("wready_after_aw", wready, 1);
    check_eq("awready_after_aw", awready, 0);
  endtask

  task automatic send_w(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      wvalid = 1'b1;
      wlast  = (i == last_at);
      wdata  = {8{i[31:0]}};
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic take_b(input logic [5:0] id, input logic [1:0] resp);
    check_eq("bvalid", bvalid, 1);
    check_eq("wready_in_resp", wready, 0);
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("bvalid_after_b", bvalid, 0);
    check_eq("awready_after_b", awready, 1);
  endtask

  task automatic send_ar(input logic [32:0] a, input logic [3:0] len, input logic [5:0] id,
                         input logic [1:0] burst);
    check_eq("arready_before_ar", arready, 1);
    araddr = a; arlen = len; arid = id; arburst = burst; arsize = 3'd5; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("rvalid_after_ar", rvalid, 1);
    check_eq("rid", rid, id);
  endtask

  initial begin
    int ready_pat [6] = '{1, 0, 0, 1, 1, 1};
    logic [31:0] exp_lo [4] = '{32'hFFFF_FFC0, 32'hFFFF_FFE0, 32'h0000_0000, 32'h0000_0020};
    int idx;

    tick();
    tick();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_counters", {wr_cnt, rd_cnt, err_cnt}, 0);
    areset = 1'b0;
    tick();
    check_eq("post_rst_awready", awready, 1);
    check_eq("post_rst_arready", arready, 1);

    // Clean 4-beat write
    send_aw(33'h1000, 4'd3, 6'd5, 2'b01, 3'd5);
    send_w(4, 3);
    take_b(6'd5, 2'b00);
    check_eq("wr_cnt_1", wr_cnt, 1);

    // Clean 2-beat read
    send_ar(33'h0_0000_2000, 4'd1, 6'd9, 2'b01);
    check_eq("rd0_data", rdata, pat(32'h2000));
    check_eq("rd0_last", rlast, 0);
    check_eq("rd0_resp", rresp, 0);
    rready = 1'b1;
    tick();
    check_eq("rd1_valid", rvalid, 1);
    check_eq("rd1_data", rdata, pat(32'h2020));
    check_eq("rd1_last", rlast, 1);
    tick();
    rready = 1'b0;
    check_eq("rd_done_valid", rvalid, 0);
    check_eq("rd_cnt_1", rd_cnt, 1);

    // Early wlast: closes at beat 2 with SLVERR, then a following burst is accepted
    send_aw(33'h3000, 4'd3, 6'd2, 2'b01, 3'd5);
    send_w(2, 1);
    take_b(6'd2, 2'b10);
    check_eq("err_cnt_early_wlast", err_cnt, 1);
    send_aw(33'h3100, 4'd0, 6'd3, 2'b01, 3'd5);
    send_w(1, 0);
    take_b(6'd3, 2'b00);
    check_eq("wr_cnt_3", wr_cnt, 3);

    // FIXED single-beat read answers SLVERR
    send_ar(33'h40, 4'd0, 6'd4, 2'b00);
    check_eq("fixed_rresp", rresp, 2'b10);
    check_eq("fixed_rlast", rlast, 1);
    check_eq("fixed_rdata", rdata, pat(32'h40));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check_eq("fixed_rvalid_done", rvalid, 0);
    check_eq("err_cnt_fixed", err_cnt, 2);

    // 4-beat read with rready stalls, crossing the 2^33 address wrap
    send_ar(33'h1_FFFF_FFC0, 4'd3, 6'd7, 2'b01);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      check_eq("stall_rvalid", rvalid, 1);
      check_eq("stall_rdata", rdata, pat(exp_lo[idx]));
      check_eq("stall_rlast", rlast, idx == 3);
      rready = ready_pat[c][0];
      tick();
      if (ready_pat[c] != 0) idx++;
    end
    rready = 1'b0;
    check_eq("stall_done_rvalid", rvalid, 0);
    check_eq("rd_cnt_3", rd_cnt, 3);
    check_eq("err_cnt_after_stall", err_cnt, 2);

    // Reset during beat 2 of a write abandons the burst
    send_aw(33'h5000, 4'd3, 6'd1, 2'b01, 3'd5);
    send_w(1, 9);
    wvalid = 1'b1;
    areset = 1'b1;
    tick();
    check_eq("midrst_bvalid", bvalid, 0);
    check_eq("midrst_wready", wready, 0);
    check_eq("midrst_awready", awready, 0);
    check_eq("midrst_counters", {wr_cnt, rd_cnt, err_cnt}, 0);
    wvalid = 1'b0;
    areset = 1'b0;
    tick();
    send_aw(33'h6000, 4'd1, 6'd6, 2'b01, 3'd5);
    send_w(2, 1);
    take_b(6'd6, 2'b00);
    check_eq("wr_cnt_after_rst", wr_cnt, 1);

    // Erroring write and read complete on the same edge: err_cnt steps by 2
    send_aw(33'h7000, 4'd0, 6'd10, 2'b01, 3'd4);
    send_w(1, 0);
    send_ar(33'h80, 4'd0, 6'd11, 2'b10);
    check_eq("dual_bresp", bresp, 2'b10);
    check_eq("dual_rresp", rresp, 2'b10);
    check_eq("dual_err_before", err_cnt, 0);
    bready = 1'b1;
    rready = 1'b1;
    tick();
    bready = 1'b0;
    rready = 1'b0;
    check_eq("dual_err_cnt", err_cnt, 2);
    check_eq("dual_wr_cnt", wr_cnt, 2);
    check_eq("dual_rd_cnt", rd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
